// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package boot_pkg;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        RECV,
        WRITE,
        CHK,
        DONE,
        ERROR
    } bootState_e;

    localparam int BOOT_INSTR_W         = 33;
    localparam int BOOT_ADDR_W          = 9;
    localparam int BOOT_BYTES_PER_INSTR = 5;
    localparam int BOOT_TIMEOUT_CYCLES  = 1_000_000;

    // Mask of the stream bits above the instruction width; any of them set marks a malformed word.
    function automatic logic [63:0] rsvdMask(input int instrW, input int shiftW);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            m[i] = (i >= instrW) && (i < shiftW);
        end
        return m;
    endfunction

    // States in which a stream byte may be taken.
    function automatic logic acceptsByte(input bootState_e s);
        return s inside {HDR_LO, HDR_HI, RECV, CHK};
    endfunction

    // States in which the inter-byte idle timer runs.
    function automatic logic timerRuns(input bootState_e s);
        return s inside {HDR_HI, RECV, CHK};
    endfunction

endpackage

// File: rtl/boot_timeout.sv
// Idle-cycle watchdog for serial loaders: counts enabled cycles, flags the last allowed one.
// Latency: expired is combinational from the count; count updates one cycle after en/clr.
// Backpressure: none; clr has priority, the count holds (en=0) or saturates at the expiry value.
module boot_timeout
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign expired = en && (cnt == LAST);

    // Idle counter: cleared on demand, otherwise advances while enabled until the expiry value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Fills instruction memory from a byte stream (count header, 5-byte LE words, XOR checksum), then releases the core.
// Latency: imem write lands the cycle after a word's last byte; done/err/cpu_rst the cycle after the deciding byte.
// Backpressure: in_ready drops while writing and in DONE/ERROR; start only restarts from DONE or ERROR.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int INSTR_W         = BOOT_INSTR_W,
    parameter int ADDR_W          = BOOT_ADDR_W,
    parameter int BYTES_PER_INSTR = BOOT_BYTES_PER_INSTR,
    parameter int TIMEOUT_CYCLES  = BOOT_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               start,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_rst,
    output logic               done,
    output logic               err
);

    localparam int SHIFT_W = 8 * BYTES_PER_INSTR;
    localparam int CNT_W   = ADDR_W + 1;
    localparam logic [SHIFT_W-1:0] RSVD_MASK = SHIFT_W'(rsvdMask(INSTR_W, SHIFT_W));
    localparam logic [16:0]        N_MAX     = 17'(2 ** ADDR_W);
    localparam logic [2:0]         LAST_IDX  = 3'(BYTES_PER_INSTR - 1);

    bootState_e         state, stateNext;
    logic [CNT_W-1:0]   count, countNext;
    logic [CNT_W-1:0]   nWords, nWordsNext;
    logic [2:0]         index, indexNext;
    logic [7:0]         xorAcc, xorNext;
    logic [7:0]         hdrLo, hdrLoNext;
    logic [SHIFT_W-1:0] shiftReg, shiftNext;
    logic [15:0]        nHdr;
    logic               accept;
    logic               timerEn, timerClr, timerExpired, timeoutHit;

    assign accept     = in_valid & in_ready;
    assign nHdr       = {in_data, hdrLo};
    assign timerEn    = timerRuns(state);
    // WRITE neither counts nor clears, so the timer is frozen there.
    assign timerClr   = accept | (state inside {HDR_LO, DONE, ERROR});
    // A byte landing on the expiry cycle wins over the timeout.
    assign timeoutHit = timerExpired & ~accept;

    boot_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) uTimeout (
        .clk    (clk),
        .rst    (rst),
        .en     (timerEn),
        .clr    (timerClr),
        .expired(timerExpired)
    );

    // Next-state and datapath updates for the header/payload/checksum sequence.
    always_comb begin
        stateNext  = state;
        countNext  = count;
        nWordsNext = nWords;
        indexNext  = index;
        xorNext    = xorAcc;
        hdrLoNext  = hdrLo;
        shiftNext  = shiftReg;
        case (state)
            HDR_LO: begin
                if (accept) begin
                    hdrLoNext = in_data;
                    xorNext   = xorAcc ^ in_data;
                    stateNext = HDR_HI;
                end
            end
            HDR_HI: begin
                if (accept) begin
                    xorNext = xorAcc ^ in_data;
                    if ((nHdr == 16'd0) || ({1'b0, nHdr} > N_MAX)) begin
                        stateNext = ERROR;
                    end else begin
                        nWordsNext = CNT_W'(nHdr);
                        countNext  = '0;
                        indexNext  = '0;
                        stateNext  = RECV;
                    end
                end else if (timeoutHit) begin
                    stateNext = ERROR;
                end
            end
            RECV: begin
                if (accept) begin
                    // Shifting in from the top leaves byte 0 in the low lane after the last byte.
                    shiftNext = {in_data, shiftReg[SHIFT_W-1:8]};
                    xorNext   = xorAcc ^ in_data;
                    if (index == LAST_IDX) begin
                        stateNext = ((shiftNext & RSVD_MASK) != '0) ? ERROR : WRITE;
                    end else begin
                        indexNext = index + 3'd1;
                    end
                end else if (timeoutHit) begin
                    stateNext = ERROR;
                end
            end
            WRITE: begin
                countNext = count + CNT_W'(1);
                indexNext = '0;
                stateNext = ((count + CNT_W'(1)) == nWords) ? CHK : RECV;
            end
            CHK: begin
                if (accept) begin
                    stateNext = (in_data == xorAcc) ? DONE : ERROR;
                end else if (timeoutHit) begin
                    stateNext = ERROR;
                end
            end
            DONE, ERROR: begin
                if (start) begin
                    stateNext  = HDR_LO;
                    countNext  = '0;
                    nWordsNext = '0;
                    indexNext  = '0;
                    xorNext    = '0;
                    hdrLoNext  = '0;
                    shiftNext  = '0;
                end
            end
            default: begin
                stateNext = HDR_LO;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HDR_LO;
            count    <= '0;
            nWords   <= '0;
            index    <= '0;
            xorAcc   <= '0;
            hdrLo    <= '0;
            shiftReg <= '0;
        end else begin
            state    <= stateNext;
            count    <= countNext;
            nWords   <= nWordsNext;
            index    <= indexNext;
            xorAcc   <= xorNext;
            hdrLo    <= hdrLoNext;
            shiftReg <= shiftNext;
        end
    end

    // Registered outputs decoded from the next state, so nothing on in_* reaches them combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            in_ready <= acceptsByte(stateNext);
            imem_we  <= (stateNext == WRITE);
            if (stateNext == WRITE) begin
                imem_addr  <= count[ADDR_W-1:0];
                imem_wdata <= shiftNext[INSTR_W-1:0];
            end
            cpu_rst <= (stateNext == DONE);
            done    <= (stateNext == DONE);
            err     <= (stateNext == ERROR);
        end
    end

endmodule
